gcd_engine: RTL

//   Sequential GCD unit built on the magnitude compare (lt/gt/eq) plus a subtractor.

---
 rtl/gcd_engine.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gcd_engine.sv
// Sequential GCD by repeated subtraction: one compare/subtract step per cycle,
// with valid/ready handshakes on the operand and result sides.
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic             zero_err,
    output logic [WIDTH-1:0] iter_cnt,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic             zerr_q, zerr_d;
    logic             ra_zero, rb_zero, finish;

    assign lt      = (ra_q < rb_q);
    assign gt      = (ra_q > rb_q);
    assign eq      = (ra_q == rb_q);
    assign ra_zero = (ra_q == '0);
    assign rb_zero = (rb_q == '0);
    // Any zero operand or equal operands ends the computation this cycle.
    assign finish  = ra_zero || rb_zero || eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (finish) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        ra_d   = ra_q;
        rb_d   = rb_q;
        gcd_d  = gcd_q;
        iter_d = iter_q;
        zerr_d = zerr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d   = a;
                    rb_d   = b;
                    iter_d = '0;
                end
            end
            CALC: begin
                if (ra_zero && rb_zero) begin
                    gcd_d  = '0;
                    zerr_d = 1'b1;
                end else if (ra_zero) begin
                    gcd_d  = rb_q;
                    zerr_d = 1'b0;
                end else if (rb_zero || eq) begin
                    gcd_d  = ra_q;
                    zerr_d = 1'b0;
                end else begin
                    // Always subtract the smaller from the larger so nothing underflows.
                    if (gt) begin
                        ra_d = ra_q - rb_q;
                    end else begin
                        rb_d = rb_q - ra_q;
                    end
                    iter_d = (iter_q == '1) ? iter_q : iter_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q   <= '0;
            rb_q   <= '0;
            gcd_q  <= '0;
            iter_q <= '0;
            zerr_q <= 1'b0;
        end else begin
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            gcd_q  <= gcd_d;
            iter_q <= iter_d;
            zerr_q <= zerr_d;
        end
    end

    assign gcd      = gcd_q;
    assign iter_cnt = iter_q;
    assign zero_err = zerr_q;

endmodule
